// File: rtl/music_pkg.sv
// Shared constants and types for the UART note sequencer: packet headers,
// FSM state encodings and the FIFO note entry.
package music_pkg;

  localparam logic [7:0] HDR_NOTE  = 8'hA5;
  localparam logic [7:0] HDR_CTRL  = 8'hC3;
  localparam logic [7:0] CMD_FLUSH = 8'h00;

  typedef enum logic [1:0] {
    S_HDR,
    S_TONE,
    S_DUR,
    S_CMD
  } parse_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_LOAD,
    P_PLAY,
    P_GAP
  } play_state_t;

  typedef struct packed {
    logic [7:0] tone;
    logic [7:0] dur;
  } note_t;

  localparam int NOTE_W = $bits(note_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy counter.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_note_sequencer.sv
// Parses UART note/control packets into a note FIFO and plays the queued
// notes back-to-back on music_tone/tone_en, timed by an internal 1 ms tick.
//
// state  | meaning
// S_HDR  | waiting for a packet header, other bytes discarded
// S_TONE | note packet: next byte is the tone
// S_DUR  | note packet: next byte is the duration, push or drop
// S_CMD  | control packet: next byte is the command
// P_IDLE | nothing sounding, waiting for a queued note
// P_LOAD | popping the FIFO head into the timers
// P_PLAY | tone sounding, ms_left counting down
// P_GAP  | silent gap after a note
module uart_note_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV    = 12000,
  parameter int FIFO_DEPTH  = 16,
  parameter int DUR_UNIT_MS = 10,
  parameter int GAP_MS      = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  input  logic       music_stop,
  output logic [7:0] music_tone,
  output logic       tone_en,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]   GAP_LOAD  = 16'(GAP_MS);

  parse_state_t  p_state, p_nxt;
  play_state_t   pl_state, pl_nxt;
  logic [7:0]    tone_lat;
  logic          push, pop, flush, ovf_set, seg_done;
  logic          fifo_empty;
  note_t         push_note;
  note_t         head;
  logic [TW-1:0] tick;
  logic [15:0]   ms_left;
  logic [7:0]    tone_q;
  logic          en_q;

  assign flush     = uart_done && (p_state == S_CMD) && (uart_data == CMD_FLUSH);
  assign pop       = (pl_state == P_LOAD) && !flush;
  assign push_note = {tone_lat, uart_data};
  assign seg_done  = !music_stop && (tick == '0) && (ms_left == 16'd1);

  sync_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_note),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    p_nxt   = p_state;
    push    = 1'b0;
    ovf_set = 1'b0;
    if (uart_done) begin
      case (p_state)
        S_HDR: begin
          if (uart_data == HDR_NOTE)      p_nxt = S_TONE;
          else if (uart_data == HDR_CTRL) p_nxt = S_CMD;
        end
        S_TONE: p_nxt = S_DUR;
        S_DUR: begin
          p_nxt = S_HDR;
          if (uart_data != 8'h00) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   ovf_set = 1'b1;
          end
        end
        S_CMD:   p_nxt = S_HDR;
        default: p_nxt = S_HDR;
      endcase
    end
  end

  always_comb begin
    pl_nxt = pl_state;
    if (flush) begin
      pl_nxt = P_IDLE;
    end else begin
      case (pl_state)
        P_IDLE: if (!fifo_empty && !music_stop) pl_nxt = P_LOAD;
        P_LOAD: pl_nxt = P_PLAY;
        P_PLAY: if (seg_done) pl_nxt = (GAP_MS > 0) ? P_GAP : P_IDLE;
        P_GAP:  if (seg_done) pl_nxt = P_IDLE;
        default: pl_nxt = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_state  <= S_HDR;
      pl_state <= P_IDLE;
      tone_lat <= 8'h00;
      overflow <= 1'b0;
    end else begin
      p_state  <= p_nxt;
      pl_state <= pl_nxt;
      if (uart_done && p_state == S_TONE) tone_lat <= uart_data;
      if (flush)        overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  // The same down-counters time both the note and the gap that follows it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tone_q  <= 8'h00;
      en_q    <= 1'b0;
      tick    <= '0;
      ms_left <= 16'd0;
    end else if (flush) begin
      tone_q  <= 8'h00;
      en_q    <= 1'b0;
      tick    <= '0;
      ms_left <= 16'd0;
    end else begin
      case (pl_state)
        P_LOAD: begin
          tone_q  <= head.tone;
          en_q    <= (head.tone != 8'h00);
          ms_left <= 16'(head.dur) * 16'(DUR_UNIT_MS);
          tick    <= TICK_LAST;
        end
        P_PLAY, P_GAP: begin
          if (!music_stop) begin
            if (tick == '0) begin
              tick    <= TICK_LAST;
              ms_left <= ms_left - 16'd1;
              if (ms_left == 16'd1) begin
                tone_q <= 8'h00;
                en_q   <= 1'b0;
                if (pl_state == P_PLAY) ms_left <= GAP_LOAD;
              end
            end else begin
              tick <= tick - TW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign music_tone = music_stop ? 8'h00 : tone_q;
  assign tone_en    = en_q && !music_stop;
  assign busy       = (pl_state != P_IDLE) || !fifo_empty;

endmodule

// File: doc/uart_note_sequencer.md
Name: uart_note_sequencer

Overview:
- Sits between the UART receiver and the beeper.
- Parses UART byte packets into (tone, duration) note events and buffers them in a small FIFO.
- Plays the buffered notes back-to-back on `music_tone` / `tone_en`, timing each note with an internal 1 ms tick.
- Replaces the direct receiver-to-player path; the beeper consumes `music_tone` and `tone_en` unchanged.

Parameters:
- `TICK_DIV`, 12000: `sys_clk` cycles per 1 ms tick (12 MHz system clock).
- `FIFO_DEPTH`, 16: note FIFO entries; must be a power of 2, minimum 2.
- `DUR_UNIT_MS`, 10: milliseconds per duration-byte LSB.
- `GAP_MS`, 20: silent gap in ms inserted after every note; 0 disables the gap.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous reset, active-low.
- `uart_done`  in  1  one-cycle strobe: `uart_data` is valid this cycle.
- `uart_data`  in  8  received byte.
- `music_stop`  in  1  level: pause playback while high.
- `music_tone`  out  8  tone index to the beeper; 0 = rest.
- `tone_en`  out  1  beeper enable; high only while a non-zero tone is sounding.
- `busy`  out  1  high when the player is not idle or the FIFO is not empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky: a note packet was dropped because the FIFO was full.

Behaviour:
- Reset: asynchronous, active-low (`sys_rst_n` low).
  - All outputs are 0.
  - FIFO is empty, parser is in `S_HDR`, player is in `P_IDLE`.
  - Reset mid-note aborts immediately; no residual state survives.
- Packet formats:
  - Note packet: `0xA5`, tone byte, duration byte.
  - Control packet: `0xC3`, command byte. Command `0x00` = flush. Any other command value is ignored.
- Parser FSM (advances only on `uart_done`):
  - `S_HDR`: `0xA5` -> `S_TONE`; `0xC3` -> `S_CMD`; any other byte is discarded (resync).
  - `S_TONE`: latch tone -> `S_DUR`.
  - `S_DUR`, duration 0: drop the packet, -> `S_HDR`.
  - `S_DUR`, duration non-zero, FIFO not full: push {tone, dur} -> `S_HDR`.
  - `S_DUR`, duration non-zero, FIFO full: drop the packet, set `overflow`, -> `S_HDR`.
  - `S_CMD`: execute the command -> `S_HDR`.
  - There is no inter-byte timeout.
- Flush (`0xC3 0x00`):
  - Empties the FIFO, clears `overflow`, and forces the player to `P_IDLE` on the next cycle.
  - `music_tone` and `tone_en` go to 0 on that same next cycle.
- FIFO:
  - Synchronous, registered; push and pop in the same cycle are legal in any occupancy.
  - Push while full with a simultaneous pop is accepted and `overflow` is not set.
  - Pop occurs only in `P_LOAD`, so the FIFO is never popped while empty.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Player FSM:
  - `P_IDLE`: -> `P_LOAD` when the FIFO is not empty and `music_stop` is low.
  - `P_LOAD`: pop the FIFO.
    - Load `ms_left` = dur * `DUR_UNIT_MS` (16-bit, maximum 2550).
    - Clear the tick counter; drive `music_tone` = tone and `tone_en` = (tone != 0).
    - -> `P_PLAY`.
  - `P_PLAY`: the tick counter counts 0..`TICK_DIV`-1.
    - At `TICK_DIV`-1, `ms_left` decrements.
    - When `ms_left` reaches 0, -> `P_GAP` if `GAP_MS` > 0, else -> `P_IDLE`.
    - A note therefore lasts exactly dur * `DUR_UNIT_MS` * `TICK_DIV` cycles.
  - `P_GAP`: `music_tone` = 0 and `tone_en` = 0 for `GAP_MS` * `TICK_DIV` cycles -> `P_IDLE`.
- Latency: if the final-byte `uart_done` occurs in cycle N with the player idle and the FIFO empty:
  - the FIFO write happens in N+1;
  - `P_LOAD` is entered in N+2;
  - `music_tone` is valid from N+3.
- `music_stop` high:
  - The tick counter and `ms_left` freeze; `music_tone` and `tone_en` are forced to 0.
  - `P_IDLE` does not start a new note; the parser keeps accepting bytes.
  - On release, the interrupted note resumes with its remaining time.
  - Flush has priority over `music_stop`.
- Simultaneous events:
  - A flush and a `P_LOAD` pop in the same cycle: flush wins.
  - A `uart_done` strobe arriving during a flush cycle is processed normally.
- `busy` = (player != `P_IDLE`) || !fifo_empty.

Decomposition:
- Package `music_pkg`:
  - header constants `HDR_NOTE` = `8'hA5`, `HDR_CTRL` = `8'hC3`, `CMD_FLUSH` = `8'h00`;
  - parser and player state encodings;
  - FIFO entry type {tone[7:0], dur[7:0]}.
- Sub-module `sync_fifo`: parameterised width and depth; ports push, pop, din, dout, full, empty.

Test Plan (`TICK_DIV`=4, `DUR_UNIT_MS`=1, `GAP_MS`=2 unless stated):
- Single note: send `A5 07 03` -> `music_tone`=7 and `tone_en`=1 from N+3 for exactly 12 cycles, then 8 cycles of 0, then `busy`=0.
- Resync/drop:
  - send `11 A5 05 00 A5 02 01` -> only tone 2 plays, for 4 cycles;
  - tone 5 never appears; `overflow` stays 0.
- Overflow: hold `music_stop`=1, send 17 note packets with `FIFO_DEPTH`=16 -> `fifo_full`=1, `overflow`=1; after release, exactly 16 notes play in order.
- Pause/resume: during a dur=5 note, raise `music_stop` for 30 cycles after 8 cycles of playing.
  - `music_tone`=0 while paused;
  - the note then plays the remaining 12 cycles (20 playing cycles in total).
- Flush: queue 3 notes, send `C3 00` mid-first-note -> tone to 0 the next cycle, FIFO empty, `busy`=0, `overflow` cleared.
- Reset mid-note: assert `sys_rst_n`=0 asynchronously -> all outputs 0 immediately; after release, a new `A5 03 01` plays normally.
